// File: rtl/oam_dma_controller_pkg.sv
// Shared CPU-side definitions used by the sprite DMA engine.
//   dma_state_t  : OAM DMA sequencer states
//   OAMDMA_ADDR  : CPU register that starts a sprite DMA ($4014)
//   OAMDATA_ADDR : PPU OAM data port that receives the copied bytes ($2004)
package oam_dma_controller_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite DMA engine. A CPU write to $4014 stalls the CPU, then the engine
// copies 256 bytes from page {data,8'h00} into OAMDATA ($2004) using
// alternating read/write bus cycles. While dma_bus_own is high the CPU-level
// mux routes dma_addr/dma_r_en/dma_w_data to memory instead of the CPU bus.
//
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   clock_en         : CPU-cycle enable; all state advances only when high
//   cpu_addr/cpu_r_en/cpu_w_data : CPU-side bus request (trigger detection)
//   mem_r_data       : registered memory read data (valid during WRITE)
//   dma_bus_own      : bus mux select, 1 = DMA drives the bus
//   dma_addr/dma_r_en/dma_w_data : DMA bus request
//   cpu_stall        : freezes the CPU while the transfer runs
//   dma_done         : one-cycle pulse after the last OAM write
module oam_dma_controller
  import oam_dma_controller_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_r_en,
  input  logic [7:0]  cpu_w_data,
  input  logic [7:0]  mem_r_data,
  output logic        dma_bus_own,
  output logic [15:0] dma_addr,
  output logic        dma_r_en,
  output logic [7:0]  dma_w_data,
  output logic        cpu_stall,
  output logic        dma_done
);

  dma_state_t state, state_nxt;
  logic       put_cycle;
  logic [7:0] page;
  logic [7:0] index;
  logic       trigger;
  logic       last_write;

  // Only IDLE listens for $4014; outside IDLE the CPU is stalled anyway.
  assign trigger    = clock_en && (state == DMA_IDLE) &&
                      (cpu_addr == OAMDMA_ADDR) && !cpu_r_en;
  assign last_write = (state == DMA_WRITE) && (index == 8'hFF);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= DMA_IDLE;
      put_cycle <= 1'b0;
      page      <= 8'h00;
      index     <= 8'h00;
      dma_done  <= 1'b0;
    end else if (clock_en) begin
      state     <= state_nxt;
      put_cycle <= ~put_cycle;
      dma_done  <= last_write;
      if (trigger) begin
        page  <= cpu_w_data;
        index <= 8'h00;
      end else if (state == DMA_WRITE) begin
        index <= index + 8'h01;   // FF->00 wrap ends the transfer
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DMA_IDLE:  if (trigger) state_nxt = DMA_HALT;
      // Parity has already toggled since the trigger: put_cycle==1 here
      // means the trigger was a get cycle, so the next cycle is a get cycle.
      DMA_HALT:  state_nxt = put_cycle ? DMA_READ : DMA_ALIGN;
      DMA_ALIGN: state_nxt = DMA_READ;
      DMA_READ:  state_nxt = DMA_WRITE;
      DMA_WRITE: state_nxt = last_write ? DMA_IDLE : DMA_READ;
      default:   state_nxt = DMA_IDLE;
    endcase
  end

  always_comb begin
    dma_bus_own = 1'b1;
    cpu_stall   = 1'b1;
    dma_addr    = {page, index};
    dma_r_en    = 1'b1;
    dma_w_data  = 8'h00;
    case (state)
      DMA_IDLE: begin
        dma_bus_own = 1'b0;
        cpu_stall   = 1'b0;
        dma_addr    = 16'h0000;
      end
      DMA_WRITE: begin
        dma_addr   = OAMDATA_ADDR;
        dma_r_en   = 1'b0;
        dma_w_data = mem_r_data;  // byte latched by memory at the READ edge
      end
      default: ;                  // HALT/ALIGN/READ: (dummy) read of {page,index}
    endcase
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
module tb_oam_dma_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clock_en = 1'b0;
  logic [15:0] cpu_addr = 16'h8000;
  logic        cpu_r_en = 1'b1;
  logic [7:0]  cpu_w_data = 8'h00;
  logic [7:0]  mem_r_data = 8'h00;
  logic        dma_bus_own;
  logic [15:0] dma_addr;
  logic        dma_r_en;
  logic [7:0]  dma_w_data;
  logic        cpu_stall;
  logic        dma_done;

  int n_cmp = 0;
  int n_bad = 0;

  oam_dma_controller dut (
    .clock(clock), .reset_n(reset_n), .clock_en(clock_en),
    .cpu_addr(cpu_addr), .cpu_r_en(cpu_r_en), .cpu_w_data(cpu_w_data),
    .mem_r_data(mem_r_data), .dma_bus_own(dma_bus_own), .dma_addr(dma_addr),
    .dma_r_en(dma_r_en), .dma_w_data(dma_w_data), .cpu_stall(cpu_stall),
    .dma_done(dma_done)
  );

  always #5 clock = ~clock;

  // Environment: bus mux and a registered memory that holds r_data on writes.
  logic [7:0]  mem [0:65535];
  logic [15:0] bus_addr;
  logic        bus_r_en;
  assign bus_addr = dma_bus_own ? dma_addr : cpu_addr;
  assign bus_r_en = dma_bus_own ? dma_r_en : cpu_r_en;

  always @(posedge clock)
    if (clock_en && bus_r_en) mem_r_data <= mem[bus_addr];

  // Reference parity: get cycle (0) after reset, toggles every enabled cycle.
  logic tb_par;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) tb_par <= 1'b0;
    else if (clock_en) tb_par <= ~tb_par;

  // Trace of enabled cycles after a trigger.
  bit          mon_on = 1'b0;
  bit          q_own[$], q_ren[$], q_stall[$], q_done[$], q_par[$];
  logic [15:0] q_addr[$];
  logic [7:0]  q_wd[$];

  always @(negedge clock)
    if (mon_on && clock_en && reset_n) begin
      q_own.push_back(dma_bus_own);
      q_ren.push_back(dma_r_en);
      q_stall.push_back(cpu_stall);
      q_done.push_back(dma_done);
      q_par.push_back(tb_par);
      q_addr.push_back(dma_addr);
      q_wd.push_back(dma_w_data);
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 2ms", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    logic [31:0] r;
    r = $urandom;
    cpu_addr   = {1'b1, r[14:0]};   // ROM space, never $4014
    cpu_r_en   = 1'b1;
    cpu_w_data = r[23:16];
  endtask

  task automatic fill_page(input logic [7:0] pg, input bit pattern);
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      mem[{pg, i[7:0]}] = pattern ? (i[7:0] ^ 8'h5A) : r[7:0];
    end
  endtask

  // Issues the $4014 write on a cycle of the requested parity.
  task automatic start_dma(input logic [7:0] pg, input bit want_put);
    int g;
    g = 0;
    idle_bus();
    while (tb_par != want_put && g < 4) begin step(); g++; end
    q_own.delete(); q_ren.delete(); q_stall.delete(); q_done.delete();
    q_par.delete(); q_addr.delete(); q_wd.delete();
    cpu_addr = 16'h4014; cpu_r_en = 1'b0; cpu_w_data = pg;
    step();
    mon_on = 1'b1;
    idle_bus();
  endtask

  task automatic run_until_done(input string name, input bit gap);
    int guard, gap_bad;
    bit seen;
    guard = 0; gap_bad = 0; seen = 0;
    while (!seen && guard < 3000) begin
      if (gap && dma_bus_own && !dma_r_en) begin
        clock_en = 1'b0;
        repeat (3) step();
        if (dma_addr !== 16'h2004 || dma_r_en !== 1'b0 || dma_bus_own !== 1'b1) gap_bad++;
        clock_en = 1'b1;
      end
      step();
      guard++;
      if (q_done.size() > 0 && q_done[q_done.size()-1]) seen = 1;
    end
    step(); step();
    mon_on = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s done_timeout: dma_done not seen in %0d cycles, required within 3000", name, guard);
    end
    if (gap) begin
      n_cmp++;
      if (gap_bad != 0) begin
        n_bad++;
        $display("FAIL %s freeze: %0d WRITE cycles changed while clock_en=0, required 0", name, gap_bad);
      end
    end
  endtask

  // Compares the recorded trace against the transfer rules.
  task automatic check_transfer(input string name, input logic [7:0] pg, input bit put);
    int n, stalls, first_free, dones, done_pos, nw, wbad, nr, rbad, pbad, first_rd, zero_rd;
    logic [7:0] jb;
    logic [15:0] exp_a;
    int bad_i;
    n = q_own.size();
    stalls = 0; first_free = -1; dones = 0; done_pos = -1;
    nw = 0; wbad = 0; nr = 0; rbad = 0; pbad = 0; first_rd = -1; zero_rd = 0; bad_i = -1;
    for (int k = 0; k < n; k++) begin
      if (q_stall[k]) stalls++;
      else if (first_free < 0) first_free = k;
      if (q_done[k]) begin dones++; if (done_pos < 0) done_pos = k; end
      if (q_own[k] && q_ren[k] && q_addr[k] == 16'h0000) zero_rd++;
      if (q_own[k] && !q_ren[k] && q_addr[k] == 16'h2004) begin
        jb = nw[7:0];
        if (nw > 255 || q_wd[k] !== mem[{pg, jb}]) begin
          wbad++;
          if (bad_i < 0) bad_i = nw;
        end
        nw++;
      end
      if (k + 1 < n && q_own[k] && q_ren[k] && q_own[k+1] && !q_ren[k+1]) begin
        jb = nr[7:0];
        exp_a = {pg, jb};
        if (q_addr[k] !== exp_a) rbad++;
        if (q_par[k] !== 1'b0) pbad++;
        if (first_rd < 0) first_rd = k;
        nr++;
      end
    end
    n_cmp++;
    if (stalls != 513 + put) begin n_bad++;
      $display("FAIL %s stall_cycles: got %0d required %0d", name, stalls, 513 + put); end
    n_cmp++;
    if (first_free != 513 + put) begin n_bad++;
      $display("FAIL %s stall_release: first unstalled cycle %0d required %0d", name, first_free, 513 + put); end
    n_cmp++;
    if (dones != 1 || done_pos != 513 + put) begin n_bad++;
      $display("FAIL %s done_pulse: count %0d at %0d required 1 at %0d", name, dones, done_pos, 513 + put); end
    n_cmp++;
    if (nw != 256) begin n_bad++;
      $display("FAIL %s write_count: got %0d required 256", name, nw); end
    n_cmp++;
    if (wbad != 0) begin n_bad++;
      $display("FAIL %s write_data: %0d bad bytes, first at index %0d, required 0", name, wbad, bad_i); end
    n_cmp++;
    if (nr != 256 || rbad != 0) begin n_bad++;
      $display("FAIL %s read_addr: %0d reads %0d wrong, required 256 reads of page %h", name, nr, rbad, pg); end
    n_cmp++;
    if (pbad != 0) begin n_bad++;
      $display("FAIL %s read_parity: %0d reads on put cycles, required 0", name, pbad); end
    n_cmp++;
    if (first_rd != 1 + put) begin n_bad++;
      $display("FAIL %s first_read: at cycle %0d after HALT start, required %0d", name, first_rd, 1 + put); end
    if (pg != 8'h00) begin
      n_cmp++;
      if (zero_rd != 0) begin n_bad++;
        $display("FAIL %s stray_read: %0d owned reads of $0000, required 0", name, zero_rd); end
    end
    n_cmp++;
    if (dma_bus_own !== 1'b0 || cpu_stall !== 1'b0) begin n_bad++;
      $display("FAIL %s idle_after: own=%b stall=%b required 0/0", name, dma_bus_own, cpu_stall); end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (dma_bus_own !== 1'b0) begin n_bad++; $display("FAIL %s own: got %b required 0", name, dma_bus_own); end
    n_cmp++;
    if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL %s stall: got %b required 0", name, cpu_stall); end
    n_cmp++;
    if (dma_addr !== 16'h0000) begin n_bad++; $display("FAIL %s addr: got %h required 0000", name, dma_addr); end
    n_cmp++;
    if (dma_r_en !== 1'b1) begin n_bad++; $display("FAIL %s r_en: got %b required 1", name, dma_r_en); end
    n_cmp++;
    if (dma_w_data !== 8'h00) begin n_bad++; $display("FAIL %s w_data: got %h required 00", name, dma_w_data); end
    n_cmp++;
    if (dma_done !== 1'b0) begin n_bad++; $display("FAIL %s done: got %b required 0", name, dma_done); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clock_en = 1'b1; idle_bus();
    repeat (3) step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_no_trigger();
    logic [15:0] addrs [3];
    bit          rens  [3];
    logic [31:0] r;
    int bad;
    addrs[0] = 16'h4014; rens[0] = 1'b1;
    addrs[1] = 16'h4015; rens[1] = 1'b0;
    addrs[2] = 16'h2014; rens[2] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        r = $urandom;
        cpu_addr = addrs[p]; cpu_r_en = rens[p]; cpu_w_data = r[7:0];
        step();
        if (cpu_stall !== 1'b0 || dma_bus_own !== 1'b0) bad++;
      end
      idle_bus();
      step();
      if (cpu_stall !== 1'b0 || dma_bus_own !== 1'b0) bad++;
      n_cmp++;
      if (bad != 0) begin n_bad++;
        $display("FAIL no_trigger_%h_r%0d: %0d stalled cycles, required 0", addrs[p], rens[p], bad); end
    end
  endtask

  task automatic test_transfer(input string name, input logic [7:0] pg, input bit put,
                               input bit pattern, input bit gap);
    fill_page(pg, pattern);
    start_dma(pg, put);
    run_until_done(name, gap);
    check_transfer(name, pg, put);
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    logic [7:0] pg;
    int wc, guard, bad;
    bit hit;
    r = $urandom;
    pg = {1'b0, r[6:0]};
    fill_page(pg, 1'b0);
    start_dma(pg, r[8]);
    wc = 0; guard = 0; hit = 0;
    while (!hit && guard < 1200) begin
      if (dma_bus_own && !dma_r_en) begin
        if (wc == 8'h40) begin
          hit = 1;
          n_cmp++;
          if (dma_w_data !== mem[{pg, 8'h40}]) begin n_bad++;
            $display("FAIL abort_wdata40: got %h required %h", dma_w_data, mem[{pg, 8'h40}]); end
        end else wc++;
      end
      if (!hit) begin step(); guard++; end
    end
    mon_on = 1'b0;
    n_cmp++;
    if (!hit) begin n_bad++;
      $display("FAIL abort_reach40: write index 40 not reached, writes seen %0d", wc); end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    repeat (2) step();
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (dma_bus_own !== 1'b0 || cpu_stall !== 1'b0 || dma_done !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++;
      $display("FAIL abort_stays_idle: %0d busy cycles after release, required 0", bad); end
    r = $urandom;
    test_transfer("restart", {1'b1, r[6:0]}, r[7], 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_no_trigger();
    test_transfer("get_page02", 8'h02, 1'b0, 1'b1, 1'b0);
    test_transfer("put_page02", 8'h02, 1'b1, 1'b1, 1'b0);
    test_transfer("gap_page02", 8'h02, 1'b0, 1'b1, 1'b1);
    r = $urandom;
    test_transfer("page_ff", 8'hFF, r[0], 1'b0, 1'b0);
    test_transfer("page_20", 8'h20, r[1], 1'b0, 1'b0);
    r = $urandom;
    test_transfer("rand_page", r[7:0], r[8], 1'b0, r[9]);
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sprite DMA engine for the CPU memory interface. It detects a CPU write to $4014 and stalls the CPU. It then copies 256 bytes from CPU page {data,8'h00} into PPU OAMDATA ($2004) by alternating read/write bus cycles. While it owns the bus, its address, read-enable and write-data outputs replace the CPU-side memory inputs at the mux in front of cpu_memory.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- clock_en  in  1  CPU-cycle enable; all state advances only on clock edges with clock_en=1
- cpu_addr  in  16  CPU-side bus address (mem_inputs addr)
- cpu_r_en  in  1  CPU-side read enable (1 read, 0 write)
- cpu_w_data  in  8  CPU-side write data
- mem_r_data  in  8  cpu_memory r_data; registered, holds its value across write cycles
- dma_bus_own  out  1  1 = bus mux selects dma_* outputs
- dma_addr  out  16  DMA bus address
- dma_r_en  out  1  DMA read enable (1 read, 0 write)
- dma_w_data  out  8  DMA write data
- cpu_stall  out  1  freeze CPU state machine and registers
- dma_done  out  1  one-cycle pulse after the final OAM write

## Operation
- Trigger: clock_en & !dma_bus_own & cpu_addr==16'h4014 & !cpu_r_en, sampled in IDLE. On trigger, latch page <= cpu_w_data and set index <= 0.
- The parity flag put_cycle resets to 0 (get cycle) and toggles on every clock_en edge, independent of state.
- States:
  - IDLE: no DMA. On trigger, go to HALT.
  - HALT: one dummy cycle; the CPU finishes its write. Next state is READ if the trigger cycle was a get cycle (put_cycle==0 at trigger), otherwise ALIGN.
  - ALIGN: one dummy cycle. Next state is READ.
  - READ: dma_addr={page,index}, dma_r_en=1. Next state is WRITE.
  - WRITE: dma_addr=16'h2004, dma_r_en=0, dma_w_data=mem_r_data. Then index <= index+1. If index==8'hFF, go to IDLE and pulse dma_done; otherwise go to READ.
- READ cycles always fall on get cycles.
- index is 8 bits and wraps FF->00. The wrap is the termination condition.
- Outputs per state:
  - cpu_stall=1 and dma_bus_own=1 in HALT, ALIGN, READ and WRITE.
  - In HALT and ALIGN: dma_r_en=1 and dma_addr={page,index}, a harmless dummy read.
  - In IDLE: dma_addr=0, dma_r_en=1, dma_w_data=0.
- dma_w_data is 0 outside WRITE.
- Writes to $4014 while not IDLE are ignored; the CPU is stalled, so none are expected.
- A write of page 8'h20 (PPU register space) is copied as-is, with no special handling.

## Timing
- Reset: state=IDLE, put_cycle=0, page=0, index=0. Outputs: dma_bus_own=0, cpu_stall=0, dma_addr=0, dma_r_en=1, dma_w_data=0, dma_done=0.
- Reset asserted mid-transfer aborts immediately (asynchronous). Bus ownership is released and the transfer is not resumed.
- Counted in clock_en cycles after the trigger cycle:
  - Trigger on a get cycle: stall lasts 513 cycles (1 HALT + 256×2).
  - Trigger on a put cycle: stall lasts 514 cycles (1 HALT + 1 ALIGN + 512).
- Stall and ownership timing:
  - cpu_stall and dma_bus_own rise in the cycle after the trigger (registered state).
  - They fall in the cycle after the final WRITE.
  - dma_done is registered: high for exactly that cycle, then cleared on the next clock_en edge.
- mem_r_data captured at the READ edge is consumed combinationally during the following WRITE, with zero added latency.
- clock_en=0 freezes everything: state, index, parity and dma_done all hold.

## Structure
- Shared cpu package entries:
  - enum dma_state_t {DMA_IDLE, DMA_HALT, DMA_ALIGN, DMA_READ, DMA_WRITE}
  - constants OAMDMA_ADDR=16'h4014 and OAMDATA_ADDR=16'h2004
- Single flat module with no sub-module; the parity flag and index counter are inline registers.
- The bus mux (cpu vs dma selected by dma_bus_own) lives in the CPU top level, not here.

## Test plan
- Write 8'h02 to $4014 on a get cycle, memory $0200–$02FF = i^8'h5A. Required: 513 stall cycles, 256 writes to $2004 in order with data 5A,5B,58,…; reads on addresses $0200..$02FF; dma_done pulses once.
- Same write issued on a put cycle. Required: 514 stall cycles; first READ appears 2 cycles after the trigger; all READs on put_cycle==0.
- clock_en held low for 3 clocks in every WRITE cycle. Required: identical write sequence, no skipped or duplicated index, total 513 enabled cycles.
- Assert reset_n at index 8'h40 during WRITE. Required: all outputs go to reset values immediately and stay idle after release. A new write to $4014 then restarts the transfer at index 0.
- Reads of $4014, and writes to $4015/$2014, in IDLE. Required: no trigger, cpu_stall stays 0.
- Page 8'hFF transfer. Required: last READ at $FFFF, index wraps to 0, return to IDLE, no read of $0000.
